// File: rtl/serial_add_ctrl_if.sv
// Operand, full-adder and result signals of the bit-serial adder sequencer.
// SERIAL_ADD_OVF_EN adds the signed-overflow result flag o_ovf.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             i_valid;
    logic             o_ready;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             i_cin;
    logic             o_fa_a;
    logic             o_fa_b;
    logic             o_fa_cin;
    logic             i_fa_sum;
    logic             i_fa_carry;
    logic             o_valid;
    logic             i_ready;
    logic [WIDTH-1:0] o_sum;
    logic             o_carry;
    logic             o_busy;
`ifdef SERIAL_ADD_OVF_EN
    logic             o_ovf;
`endif

    modport slave (
        input  i_valid, i_a, i_b, i_cin, i_fa_sum, i_fa_carry, i_ready,
        output o_ready, o_fa_a, o_fa_b, o_fa_cin, o_valid, o_sum, o_carry, o_busy
`ifdef SERIAL_ADD_OVF_EN
        , output o_ovf
`endif
    );

    modport master (
        output i_valid, i_a, i_b, i_cin, i_fa_sum, i_fa_carry, i_ready,
        input  o_ready, o_fa_a, o_fa_b, o_fa_cin, o_valid, o_sum, o_carry, o_busy
`ifdef SERIAL_ADD_OVF_EN
        , input o_ovf
`endif
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer sharing one external full adder, LSB first.
// SERIAL_ADD_OVF_EN enables the signed-overflow output o_ovf.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    serial_add_ctrl_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ready_q, ready_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Next-state and datapath: zeros shift into a/b and carry clears on the last bit,
    // so the full-adder drives fall to 0 outside RUN straight from the registers.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        sum_d    = sum_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.i_valid) begin
                    a_sh_d   = bus.i_a;
                    b_sh_d   = bus.i_b;
                    carry_d  = bus.i_cin;
                    sum_sh_d = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_RUN: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                sum_sh_d = {bus.i_fa_sum, sum_sh_q[WIDTH-1:1]};
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    sum_d   = sum_sh_d;
                    cout_d  = bus.i_fa_carry;
                    carry_d = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
                    ovf_d   = carry_q ^ bus.i_fa_carry;
`endif
                    state_d = ST_DONE;
                end else begin
                    carry_d = bus.i_fa_carry;
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (bus.i_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
        valid_d = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
    end

    // State, datapath and handshake registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            sum_q    <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ready_q  <= ready_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
`ifdef SERIAL_ADD_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign bus.o_ready  = ready_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_busy   = busy_q;
    assign bus.o_fa_a   = a_sh_q[0];
    assign bus.o_fa_b   = b_sh_q[0];
    assign bus.o_fa_cin = carry_q;
    assign bus.o_sum    = sum_q;
    assign bus.o_carry  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.o_ovf    = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random bench for serial_add_ctrl with a behavioural full adder.
// Checks o_ovf too when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [9:0] sb[$];

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    assign bus.i_fa_sum   = bus.o_fa_a ^ bus.o_fa_b ^ bus.o_fa_cin;
    assign bus.i_fa_carry = (bus.o_fa_a & bus.o_fa_b) | (bus.o_fa_a & bus.o_fa_cin) |
                            (bus.o_fa_b & bus.o_fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] res_obs();
        logic ovf;
        ovf = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
        ovf = bus.o_ovf;
`endif
        return {ovf, bus.o_carry, bus.o_sum};
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input int stall, input bit noise);
        logic [8:0] full;
        logic       ovf;
        logic [7:0] seq;
        logic [9:0] held;
        logic [9:0] exp_res;
        int n;
        full = {1'b0, a} + {1'b0, b} + 9'(cin);
        ovf  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
        ovf  = (a[7] == b[7]) && (full[7] != a[7]);
`endif
        n = 0;
        while (bus.o_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_wait", 32'(n < 50), 32'd1);
        bus.i_a = a; bus.i_b = b; bus.i_cin = cin; bus.i_valid = 1'b1;
        @(posedge clk); #1;
        sb.push_back({ovf, full});
        bus.i_valid = 1'b0;
        bus.i_a = 8'($urandom); bus.i_b = 8'($urandom); bus.i_cin = 1'($urandom);
        chk("accept_busy_ready", {30'd0, bus.o_busy, bus.o_ready}, 32'd2);
        n = 0; seq = 8'd0;
        while (bus.o_valid !== 1'b1 && n < 40) begin
            if (n < 8) seq[n] = bus.o_fa_a;
            if (noise) bus.i_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1; n++;
        end
        chk("latency", n, 32'd8);
        chk("fa_a_seq", {24'd0, seq}, {24'd0, a});
        held = res_obs();
        for (int i = 0; i < stall; i++) begin
            if (noise) bus.i_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            chk("stall_valid", {31'd0, bus.o_valid}, 32'd1);
            chk("stall_hold", {22'd0, res_obs()}, {22'd0, held});
        end
        chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            exp_res = sb.pop_front();
            chk("result", {22'd0, res_obs()}, {22'd0, exp_res});
        end
        bus.i_ready = 1'b1;
        bus.i_valid = noise;
        @(posedge clk); #1;
        bus.i_ready = 1'b0;
        chk("post_hs_vrb", {29'd0, bus.o_valid, bus.o_ready, bus.o_busy}, 32'd2);
        chk("post_hs_retain", {22'd0, res_obs()}, {22'd0, held});
        bus.i_valid = 1'b0;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0;
        bus.i_valid = 1'b0; bus.i_ready = 1'b0;
        bus.i_a = 8'd0; bus.i_b = 8'd0; bus.i_cin = 1'b0;
        #12;
        chk("rst_ctrl", {29'd0, bus.o_ready, bus.o_valid, bus.o_busy}, 32'd4);
        chk("rst_fa", {29'd0, bus.o_fa_a, bus.o_fa_b, bus.o_fa_cin}, 32'd0);
        chk("rst_result", {22'd0, res_obs()}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(8'h0F, 8'h01, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 0, 1'b0);
        run_op(8'h7F, 8'h01, 1'b0, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 0, 1'b0);
        run_op(8'h00, 8'h00, 1'b0, 0, 1'b0);
        run_op(8'hA5, 8'h3C, 1'b1, 5, 1'b1);

        // Reset mid-RUN: partial result must vanish without a clock edge.
        bus.i_a = 8'hFF; bus.i_b = 8'hFF; bus.i_cin = 1'b1; bus.i_valid = 1'b1;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_fa", {29'd0, bus.o_fa_a, bus.o_fa_b, bus.o_fa_cin}, 32'd7);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ctrl", {29'd0, bus.o_ready, bus.o_valid, bus.o_busy}, 32'd4);
        chk("async_rst_fa", {29'd0, bus.o_fa_a, bus.o_fa_b, bus.o_fa_cin}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_idle", {29'd0, bus.o_ready, bus.o_valid, bus.o_busy}, 32'd4);
        run_op(8'h12, 8'h34, 1'b0, 0, 1'b0);

        for (int k = 0; k < 100; k++) begin
            run_op(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)));
        end

        chk("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
